// File: rtl/carregador_obstaculos_pkg.sv
// Shared definitions for the obstacle map loader: FSM state encoding and
// size derivation helpers.
package carregador_obstaculos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_WAIT_BYTE = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } estado_t;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int BYTE_WIDTH_DEF = 8;

    function automatic int num_nodes(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Words needed to cover the whole map; the last word may be partly unused.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/carregador_obstaculos_desserializador_bits.sv
// Word-to-bit deserializer: holds one host word and hands it out LSB first,
// flagging the last bit of the word.
module desserializador_bits #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [BYTE_WIDTH-1:0] data_in,
    output logic                  bit_out,
    output logic                  last_bit
);

    localparam int CNT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_WIDTH - 1);

    logic [BYTE_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shift_q <= data_in;
            bit_cnt <= '0;
        end else if (shift) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign bit_out  = shift_q[0];
    assign last_bit = (bit_cnt == LAST_CNT);

endmodule

// File: rtl/carregador_obstaculos.sv
// Obstacle map loader: unpacks host words into single-bit memory writes and
// clears the whole map on command.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start/clear, address counter held at 0
// CLEAR      | writing 0 to every node, one per cycle
// WAIT_BYTE  | ready for the next host word
// WRITE      | emitting the captured word one bit per cycle, LSB first
// DONE       | map complete, one-cycle done pulse issued from here
module carregador_obstaculos
    import carregador_obstaculos_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic                  clear_in,
    input  logic                  abort_in,
    input  logic                  byte_valid_in,
    input  logic [BYTE_WIDTH-1:0] byte_data_in,
    output logic                  byte_ready_out,
    output logic                  obstaculos_wr_enable_out,
    output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
    output logic                  obstaculos_wr_data_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(num_nodes(ADDR_WIDTH) - 1);

    estado_t               state, next_state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  wr_req;
    logic                  wr_bit;
    logic                  addr_clr;
    logic                  des_load;
    logic                  des_shift;
    logic                  des_bit;
    logic                  des_last;
    logic                  aborting;

    assign aborting       = abort_in && (state != ST_IDLE);
    // Gated by abort so a word offered in the abort cycle is not swallowed.
    assign byte_ready_out = (state == ST_WAIT_BYTE) && !abort_in;

    desserializador_bits #(
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_desserializador (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (des_load),
        .shift   (des_shift),
        .data_in (byte_data_in),
        .bit_out (des_bit),
        .last_bit(des_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_req     = 1'b0;
        wr_bit     = 1'b0;
        addr_clr   = 1'b0;
        des_load   = 1'b0;
        des_shift  = 1'b0;
        case (state)
            ST_IDLE: begin
                addr_clr = 1'b1;
                if (clear_in) begin
                    next_state = ST_CLEAR;
                end else if (start_in) begin
                    next_state = ST_WAIT_BYTE;
                end
            end
            ST_CLEAR: begin
                wr_req = 1'b1;
                if (addr_cnt == LAST_ADDR) begin
                    next_state = ST_DONE;
                end
            end
            ST_WAIT_BYTE: begin
                if (byte_valid_in && byte_ready_out) begin
                    des_load   = 1'b1;
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_req    = 1'b1;
                wr_bit    = des_bit;
                des_shift = 1'b1;
                // Map end takes priority: leftover bits of the final word are dropped.
                if (addr_cnt == LAST_ADDR) begin
                    next_state = ST_DONE;
                end else if (des_last) begin
                    next_state = ST_WAIT_BYTE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if (aborting) begin
            next_state = ST_IDLE;
            wr_req     = 1'b0;
            des_load   = 1'b0;
            des_shift  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (addr_clr) begin
            addr_cnt <= '0;
        end else if (wr_req) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Outputs reflect the action taken in the state just left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obstaculos_wr_enable_out <= 1'b0;
            obstaculos_wr_addr_out   <= '0;
            obstaculos_wr_data_out   <= 1'b0;
            busy_out                 <= 1'b0;
            done_out                 <= 1'b0;
        end else begin
            obstaculos_wr_enable_out <= wr_req;
            obstaculos_wr_addr_out   <= addr_cnt;
            obstaculos_wr_data_out   <= wr_bit;
            busy_out                 <= !aborting && ((state == ST_CLEAR) ||
                                                      (state == ST_WAIT_BYTE) ||
                                                      (state == ST_WRITE));
            done_out                 <= !aborting && (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_carregador_obstaculos.sv
// Self-checking bench for carregador_obstaculos: randomized word streams checked
// against a map-level model of the expected write sequence.
module tb_carregador_obstaculos;

    localparam int NN  = 256;
    localparam int BW  = 8;
    localparam int SNN = 16;
    localparam int SBW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       d_start = 0, d_clear = 0, d_abort = 0, d_valid = 0;
    logic [7:0] d_data = '0;
    logic       d_ready, d_wr_en, d_wr_data, d_busy, d_done;
    logic [7:0] d_addr;

    logic       s_start = 0, s_clear = 0, s_abort = 0, s_valid = 0;
    logic [4:0] s_data = '0;
    logic       s_ready, s_wr_en, s_wr_data, s_busy, s_done;
    logic [3:0] s_addr;

    carregador_obstaculos #(.ADDR_WIDTH(8), .BYTE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(d_start), .clear_in(d_clear),
        .abort_in(d_abort), .byte_valid_in(d_valid), .byte_data_in(d_data),
        .byte_ready_out(d_ready), .obstaculos_wr_enable_out(d_wr_en),
        .obstaculos_wr_addr_out(d_addr), .obstaculos_wr_data_out(d_wr_data),
        .busy_out(d_busy), .done_out(d_done));

    carregador_obstaculos #(.ADDR_WIDTH(4), .BYTE_WIDTH(5)) dut_small (
        .clk(clk), .rst_n(rst_n), .start_in(s_start), .clear_in(s_clear),
        .abort_in(s_abort), .byte_valid_in(s_valid), .byte_data_in(s_data),
        .byte_ready_out(s_ready), .obstaculos_wr_enable_out(s_wr_en),
        .obstaculos_wr_addr_out(s_addr), .obstaculos_wr_data_out(s_wr_data),
        .busy_out(s_busy), .done_out(s_done));

    int checks = 0;
    int errors = 0;

    // Observed write streams and event counters
    int         cyc = 0;
    logic [7:0] wq_addr[$];
    bit         wq_data[$];
    int         wq_cyc[$];
    int         d_done_cnt = 0, d_done_cyc = 0, d_hs_cnt = 0, d_viol = 0, since_hs = 1000;
    logic [3:0] sq_addr[$];
    bit         sq_data[$];
    int         s_done_cnt = 0, s_hs_cnt = 0;

    // Reference map: bit i of the map is bit (i % width) of word (i / width)
    bit exp_bits[NN];
    bit s_exp[SNN];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (d_wr_en) begin
            wq_addr.push_back(d_addr);
            wq_data.push_back(d_wr_data);
            wq_cyc.push_back(cyc);
        end
        if (d_done) begin
            d_done_cnt++;
            d_done_cyc = cyc;
        end
        if (since_hs < 1000) since_hs++;
        if (d_ready && since_hs <= BW) d_viol++;
        if (d_valid && d_ready) begin
            d_hs_cnt++;
            since_hs = 0;
        end
        if (s_wr_en) begin
            sq_addr.push_back(s_addr);
            sq_data.push_back(s_wr_data);
        end
        if (s_done) s_done_cnt++;
        if (s_valid && s_ready) s_hs_cnt++;
    end

    task automatic clear_obs();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        sq_addr.delete(); sq_data.delete();
        d_done_cnt = 0; d_hs_cnt = 0; d_viol = 0; since_hs = 1000;
        s_done_cnt = 0; s_hs_cnt = 0;
    endtask

    task automatic pulse_d(input bit clr, input bit st);
        @(posedge clk); #1;
        d_clear = clr; d_start = st;
        @(posedge clk); #1;
        d_clear = 0; d_start = 0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, output bit ok);
        ok = 0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        d_valid = 1; d_data = w;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (d_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        d_valid = 0;
    endtask

    task automatic s_send_word(input logic [4:0] w, output bit ok);
        ok = 0;
        s_valid = 1; s_data = w;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        s_valid = 0;
    endtask

    task automatic wait_d_done(input int limit);
        for (int k = 0; k < limit && d_done_cnt == 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fill_random_words(input int nwords, output logic [7:0] words[32]);
        for (int w = 0; w < 32; w++) words[w] = '0;
        for (int w = 0; w < nwords; w++) begin
            words[w] = 8'($urandom);
            for (int b = 0; b < BW; b++) exp_bits[w*BW + b] = words[w][b];
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #23;
        checks++; if (d_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", d_wr_en); end
        checks++; if (d_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", d_addr); end
        checks++; if (d_wr_data !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", d_wr_data); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", d_busy); end
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d_done); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", d_ready); end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clear();
        int n;
        clear_obs();
        pulse_d(1, 0);
        wait_d_done(400);
        n = wq_addr.size();
        checks++; if (n !== NN) begin errors++; $display("FAIL clear_count got %0d want %0d", n, NN); end
        for (int i = 0; i < n && i < NN; i++) begin
            checks++;
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== 1'b0 || (i > 0 && wq_cyc[i] != wq_cyc[i-1] + 1)) begin
                errors++;
                $display("FAIL clear_write[%0d] got addr %0d data %b cyc %0d want addr %0d data 0 consecutive", i, wq_addr[i], wq_data[i], wq_cyc[i], i);
            end
        end
        checks++; if (d_done_cnt !== 1) begin errors++; $display("FAIL clear_done_count got %0d want 1", d_done_cnt); end
        if (n > 0) begin
            checks++;
            if (d_done_cyc != wq_cyc[n-1] + 1) begin errors++; $display("FAIL clear_done_timing got cyc %0d want %0d", d_done_cyc, wq_cyc[n-1] + 1); end
        end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_after got %b want 0", d_busy); end
    endtask

    task automatic run_load(input string name, input bit random_gaps);
        logic [7:0] words[32];
        bit ok;
        int n;
        clear_obs();
        if (random_gaps) fill_random_words(32, words);
        else begin
            for (int w = 0; w < 32; w++) begin
                words[w] = 8'hA5;
                for (int b = 0; b < BW; b++) exp_bits[w*BW + b] = words[w][b];
            end
        end
        pulse_d(0, 1);
        for (int w = 0; w < 32; w++) begin
            send_word(words[w], random_gaps ? int'($urandom_range(0, 20)) : 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL %s_accept word %0d got not accepted want accepted", name, w); end
        end
        wait_d_done(100);
        n = wq_addr.size();
        checks++; if (n !== NN) begin errors++; $display("FAIL %s_count got %0d want %0d", name, n, NN); end
        for (int i = 0; i < n && i < NN; i++) begin
            checks++;
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== exp_bits[i]) begin
                errors++;
                $display("FAIL %s_write[%0d] got addr %0d data %b want addr %0d data %b", name, i, wq_addr[i], wq_data[i], i, exp_bits[i]);
            end
        end
        checks++; if (d_done_cnt !== 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", name, d_done_cnt); end
        if (n > 0) begin
            checks++;
            if (d_done_cyc != wq_cyc[n-1] + 1) begin errors++; $display("FAIL %s_done_timing got cyc %0d want %0d", name, d_done_cyc, wq_cyc[n-1] + 1); end
        end
        checks++; if (d_hs_cnt !== 32) begin errors++; $display("FAIL %s_handshakes got %0d want 32", name, d_hs_cnt); end
        checks++; if (d_viol !== 0) begin errors++; $display("FAIL %s_ready_in_write got %0d want 0", name, d_viol); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", name, d_busy); end
    endtask

    task automatic test_back_to_back();
        run_load("b2b", 0);
    endtask

    task automatic test_random_gaps();
        run_load("gaps", 1);
    endtask

    task automatic test_abort();
        logic [7:0] words[32];
        bit ok;
        int n;
        clear_obs();
        fill_random_words(10, words);
        pulse_d(0, 1);
        for (int w = 0; w < 10; w++) begin
            send_word(words[w], int'($urandom_range(0, 3)), ok);
            checks++; if (!ok) begin errors++; $display("FAIL abort_accept word %0d got not accepted want accepted", w); end
        end
        repeat (3) @(posedge clk);
        #1 d_abort = 1;
        @(posedge clk);
        #1 d_abort = 0;
        @(negedge clk);
        checks++; if (d_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en got %b want 0", d_wr_en); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", d_busy); end
        repeat (30) @(negedge clk);
        n = wq_addr.size();
        checks++; if (n !== 75) begin errors++; $display("FAIL abort_count got %0d want 75", n); end
        for (int i = 0; i < n && i < 75; i++) begin
            checks++;
            if (wq_addr[i] !== 8'(i) || wq_data[i] !== exp_bits[i]) begin
                errors++;
                $display("FAIL abort_write[%0d] got addr %0d data %b want addr %0d data %b", i, wq_addr[i], wq_data[i], i, exp_bits[i]);
            end
        end
        checks++; if (d_done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", d_done_cnt); end
        run_load("reload", 1);
    endtask

    task automatic test_small_map();
        logic [4:0] words[4];
        bit ok;
        int n;
        clear_obs();
        for (int w = 0; w < 4; w++) begin
            words[w] = 5'($urandom);
            for (int b = 0; b < SBW; b++) if (w*SBW + b < SNN) s_exp[w*SBW + b] = words[w][b];
        end
        @(posedge clk); #1 s_start = 1;
        @(posedge clk); #1 s_start = 0;
        for (int w = 0; w < 4; w++) begin
            s_send_word(words[w], ok);
            checks++; if (!ok) begin errors++; $display("FAIL small_accept word %0d got not accepted want accepted", w); end
        end
        s_valid = 1; s_data = 5'($urandom);
        for (int k = 0; k < 50 && s_done_cnt == 0; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        s_valid = 0;
        n = sq_addr.size();
        checks++; if (n !== SNN) begin errors++; $display("FAIL small_count got %0d want %0d", n, SNN); end
        for (int i = 0; i < n && i < SNN; i++) begin
            checks++;
            if (sq_addr[i] !== 4'(i) || sq_data[i] !== s_exp[i]) begin
                errors++;
                $display("FAIL small_write[%0d] got addr %0d data %b want addr %0d data %b", i, sq_addr[i], sq_data[i], i, s_exp[i]);
            end
        end
        checks++; if (s_done_cnt !== 1) begin errors++; $display("FAIL small_done_count got %0d want 1", s_done_cnt); end
        checks++; if (s_hs_cnt !== 4) begin errors++; $display("FAIL small_handshakes got %0d want 4", s_hs_cnt); end
    endtask

    task automatic test_start_clear_reset();
        logic [7:0] words[32];
        bit ok;
        int n, nz;
        clear_obs();
        pulse_d(1, 1);
        wait_d_done(400);
        n = wq_addr.size();
        nz = 0;
        foreach (wq_data[i]) if (wq_data[i] !== 1'b0) nz++;
        checks++; if (n !== NN) begin errors++; $display("FAIL both_count got %0d want %0d", n, NN); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL both_nonzero_data got %0d want 0", nz); end
        checks++; if (d_done_cnt !== 1) begin errors++; $display("FAIL both_done_count got %0d want 1", d_done_cnt); end

        clear_obs();
        fill_random_words(4, words);
        pulse_d(0, 1);
        for (int w = 0; w < 4; w++) send_word(words[w], 0, ok);
        @(posedge clk); #2;
        checks++; if (d_wr_en !== 1'b1) begin errors++; $display("FAIL rst_pre_write got %b want 1", d_wr_en); end
        #1 rst_n = 0;
        #1;
        checks++; if (d_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", d_wr_en); end
        checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", d_busy); end
        checks++; if (d_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", d_addr); end
        checks++; if (d_wr_data !== 1'b0) begin errors++; $display("FAIL rst_data got %b want 0", d_wr_data); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (d_ready !== 1'b0 || d_busy !== 1'b0) begin errors++; $display("FAIL rst_idle got ready %b busy %b want 0 0", d_ready, d_busy); end

        clear_obs();
        pulse_d(0, 1);
        send_word(8'h3C, 0, ok);
        repeat (12) @(negedge clk);
        n = wq_addr.size();
        checks++; if (n !== BW) begin errors++; $display("FAIL restart_count got %0d want %0d", n, BW); end
        if (n > 0) begin
            checks++;
            if (wq_addr[0] !== 8'h00 || wq_data[2] !== 1'b1) begin errors++; $display("FAIL restart_first got addr %0d bit2 %b want addr 0 bit2 1", wq_addr[0], wq_data[2]); end
        end
        @(posedge clk); #1 d_abort = 1;
        @(posedge clk); #1 d_abort = 0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_random_gaps();
        test_abort();
        test_small_map();
        test_start_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
